// File: rtl/ssram_ctrl_pkg.sv
// ssram_ctrl_pkg
// Shared types and constants for the synchronous-burst SRAM controller:
//   state_t   - controller FSM states
//   DATA_W    - SRAM data width (four 9-bit byte lanes)
//   ADDR_W    - SRAM word address width
//   BURST_LEN - beats in a linear burst
//   beats_for - beat-counter load value for a command (remaining beats - 1)
package ssram_ctrl_pkg;

    localparam int DATA_W    = 36;
    localparam int ADDR_W    = 19;
    localparam int BURST_LEN = 4;
    localparam int BEAT_W    = $clog2(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_TAIL,
        WR,
        SLEEP,
        WAKE
    } state_t;

    typedef logic [BEAT_W-1:0] beat_t;

    function automatic beat_t beats_for(input logic burst4);
        return burst4 ? beat_t'(BURST_LEN - 1) : '0;
    endfunction

endpackage

// File: rtl/ssram_zz_timer.sv
// ssram_zz_timer
// Idle-time and wake-recovery sequencing for the SRAM ZZ (sleep) pin.
//   CLK, RST   - clock, synchronous active-high reset
//   state      - current controller state
//   req        - host command request
//   sleep_go   - IDLE -> SLEEP this cycle (IDLE_ZZ idle cycles reached)
//   wake_go    - SLEEP -> WAKE this cycle (request seen while asleep)
//   wake_done  - WAKE -> IDLE this cycle (recovery time elapsed)
//   zz         - registered ZZ pin
// IDLE_ZZ = 0 disables sleep entry entirely.
module ssram_zz_timer
    import ssram_ctrl_pkg::*;
#(
    parameter int IDLE_ZZ     = 64,
    parameter int ZZ_RECOVERY = 2
) (
    input  logic   CLK,
    input  logic   RST,
    input  state_t state,
    input  logic   req,
    output logic   sleep_go,
    output logic   wake_go,
    output logic   wake_done,
    output logic   zz
);

    localparam int IC_W = (IDLE_ZZ > 1) ? $clog2(IDLE_ZZ) : 1;
    localparam int RC_W = (ZZ_RECOVERY > 0) ? $clog2(ZZ_RECOVERY + 1) : 1;
    localparam logic [IC_W-1:0] IDLE_LAST = IC_W'((IDLE_ZZ > 0) ? IDLE_ZZ - 1 : 0);
    localparam logic [RC_W-1:0] REC_LOAD  = RC_W'(ZZ_RECOVERY);

    logic [IC_W-1:0] idle_cnt;
    logic [RC_W-1:0] rec_cnt;

    // Sleep is decided on the cycle that would make the count reach IDLE_ZZ,
    // so ZZ rises in the cycle right after the IDLE_ZZ-th idle cycle.
    always_comb begin
        sleep_go  = (IDLE_ZZ != 0) && (state == IDLE) && !req && (idle_cnt == IDLE_LAST);
        wake_go   = (state == SLEEP) && req;
        wake_done = (state == WAKE) && (rec_cnt <= RC_W'(1));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idle_cnt <= '0;
            rec_cnt  <= '0;
            zz       <= 1'b0;
        end else begin
            if ((state == IDLE) && !req && !sleep_go) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end

            if (wake_go) begin
                rec_cnt <= REC_LOAD;
            end else if ((state == WAKE) && (rec_cnt != '0)) begin
                rec_cnt <= rec_cnt - 1'b1;
            end

            if (sleep_go) begin
                zz <= 1'b1;
            end else if (wake_go) begin
                zz <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ssram_burst_ctrl.sv
// ssram_burst_ctrl
// Host-side command controller for a pipelined synchronous-burst SRAM
// (ADSC-started, ADV-advanced, linear burst order, SRAM does the wrap).
// Host side:
//   req/we/addr/burst4/be - command, held until ack
//   wdata/wd_pop          - show-ahead write beat, popped when wd_pop is high
//   ack/busy              - accept pulse, not-idle flag
//   rdata/rdata_valid/rbeat - registered read beat, qualifier, word index
// SRAM side:
//   ADDR, ADSC_N, ADV_N, OE_N, BWE_N, BWa_N..BWd_N, CE1_N, ZZ - registered
//   GW_N, ADSP_N, CE2, CE3_N, MODE - tied off (linear burst, ADSC only)
//   dq_out/dq_oe/dq_in    - split data bus for an external tristate
module ssram_burst_ctrl
    import ssram_ctrl_pkg::*;
#(
    parameter int IDLE_ZZ     = 64,
    parameter int ZZ_RECOVERY = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic              burst4,
    input  logic [3:0]        be,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic              busy,
    output logic              wd_pop,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic [1:0]        rbeat,
    output logic [ADDR_W-1:0] ADDR,
    output logic              ADSC_N,
    output logic              ADV_N,
    output logic              OE_N,
    output logic              BWE_N,
    output logic              BWa_N,
    output logic              BWb_N,
    output logic              BWc_N,
    output logic              BWd_N,
    output logic              CE1_N,
    output logic              ZZ,
    output logic              GW_N,
    output logic              ADSP_N,
    output logic              CE2,
    output logic              CE3_N,
    output logic              MODE,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe,
    input  logic [DATA_W-1:0] dq_in
);

    state_t      state;
    beat_t       beat_cnt;
    logic [3:0]  bw_n;
    logic        rd_cap;
    logic [1:0]  rd_word;
    logic        sleep_go;
    logic        wake_go;
    logic        wake_done;

    assign GW_N   = 1'b1;
    assign ADSP_N = 1'b1;
    assign CE2    = 1'b1;
    assign CE3_N  = 1'b0;
    assign MODE   = 1'b0;

    assign BWa_N = bw_n[0];
    assign BWb_N = bw_n[1];
    assign BWc_N = bw_n[2];
    assign BWd_N = bw_n[3];

    // wdata is show-ahead and the beat on it is consumed in the same cycle
    // wd_pop is high, so it is passed straight to the bus; dq_oe gates it.
    assign dq_out = wdata;

    ssram_zz_timer #(
        .IDLE_ZZ     (IDLE_ZZ),
        .ZZ_RECOVERY (ZZ_RECOVERY)
    ) u_zz_timer (
        .CLK       (CLK),
        .RST       (RST),
        .state     (state),
        .req       (req),
        .sleep_go  (sleep_go),
        .wake_go   (wake_go),
        .wake_done (wake_done),
        .zz        (ZZ)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            ack         <= 1'b0;
            busy        <= 1'b0;
            wd_pop      <= 1'b0;
            ADDR        <= '0;
            ADSC_N      <= 1'b1;
            ADV_N       <= 1'b1;
            OE_N        <= 1'b1;
            BWE_N       <= 1'b1;
            bw_n        <= '1;
            CE1_N       <= 1'b1;
            dq_oe       <= 1'b0;
            rd_cap      <= 1'b0;
            rd_word     <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            rbeat       <= '0;
        end else begin
            ack <= 1'b0;

            // Each RD cycle issues one SRAM access whose data is on dq_in
            // one cycle later; rd_cap marks that capture cycle.
            rd_cap      <= (state == RD);
            rdata_valid <= rd_cap;
            if (rd_cap) begin
                rdata   <= dq_in;
                rbeat   <= rd_word;
                rd_word <= rd_word + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        state    <= we ? WR : RD;
                        ack      <= 1'b1;
                        busy     <= 1'b1;
                        ADDR     <= addr;
                        ADSC_N   <= 1'b0;
                        CE1_N    <= 1'b0;
                        beat_cnt <= beats_for(burst4);
                        if (we) begin
                            OE_N   <= 1'b1;
                            BWE_N  <= 1'b0;
                            bw_n   <= ~be;
                            dq_oe  <= 1'b1;
                            wd_pop <= 1'b1;
                        end else begin
                            OE_N    <= 1'b0;
                            // Overrides the capture increment above: the last
                            // beat of the previous read has already taken it.
                            rd_word <= addr[1:0];
                        end
                    end else if (sleep_go) begin
                        state <= SLEEP;
                        busy  <= 1'b1;
                    end
                end

                RD: begin
                    ADSC_N <= 1'b1;
                    if (beat_cnt != '0) begin
                        ADV_N    <= 1'b0;
                        beat_cnt <= beat_cnt - 1'b1;
                    end else begin
                        ADV_N <= 1'b1;
                        state <= RD_TAIL;
                    end
                end

                RD_TAIL: begin
                    OE_N  <= 1'b1;
                    CE1_N <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                WR: begin
                    ADSC_N <= 1'b1;
                    if (beat_cnt != '0) begin
                        ADV_N    <= 1'b0;
                        beat_cnt <= beat_cnt - 1'b1;
                    end else begin
                        ADV_N  <= 1'b1;
                        BWE_N  <= 1'b1;
                        bw_n   <= '1;
                        dq_oe  <= 1'b0;
                        wd_pop <= 1'b0;
                        CE1_N  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end

                SLEEP: begin
                    if (wake_go) begin
                        state <= WAKE;
                    end
                end

                WAKE: begin
                    if (wake_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssram_burst_ctrl.sv
// tb_ssram_burst_ctrl
// Directed bench for ssram_burst_ctrl with a behavioural pipelined
// synchronous-burst SRAM (16 words, 9-bit byte lanes, linear wrap) and a
// show-ahead write-data source.
module tb_ssram_burst_ctrl;

    logic        CLK;
    logic        RST;
    logic        req;
    logic        we;
    logic [18:0] addr;
    logic        burst4;
    logic [3:0]  be;
    logic [35:0] wdata;
    logic        ack;
    logic        busy;
    logic        wd_pop;
    logic [35:0] rdata;
    logic        rdata_valid;
    logic [1:0]  rbeat;
    logic [18:0] ADDR;
    logic        ADSC_N, ADV_N, OE_N, BWE_N;
    logic        BWa_N, BWb_N, BWc_N, BWd_N;
    logic        CE1_N, ZZ;
    logic        GW_N, ADSP_N, CE2, CE3_N, MODE;
    logic [35:0] dq_out;
    logic        dq_oe;
    logic [35:0] dq_in;

    int checks = 0;
    int errors = 0;

    ssram_burst_ctrl #(
        .IDLE_ZZ     (64),
        .ZZ_RECOVERY (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .burst4      (burst4),
        .be          (be),
        .wdata       (wdata),
        .ack         (ack),
        .busy        (busy),
        .wd_pop      (wd_pop),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rbeat       (rbeat),
        .ADDR        (ADDR),
        .ADSC_N      (ADSC_N),
        .ADV_N       (ADV_N),
        .OE_N        (OE_N),
        .BWE_N       (BWE_N),
        .BWa_N       (BWa_N),
        .BWb_N       (BWb_N),
        .BWc_N       (BWc_N),
        .BWd_N       (BWd_N),
        .CE1_N       (CE1_N),
        .ZZ          (ZZ),
        .GW_N        (GW_N),
        .ADSP_N      (ADSP_N),
        .CE2         (CE2),
        .CE3_N       (CE3_N),
        .MODE        (MODE),
        .dq_out      (dq_out),
        .dq_oe       (dq_oe),
        .dq_in       (dq_in)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Write-data source: the beat at the head is shown until popped.
    logic [35:0] wq [0:15];
    int unsigned wptr;
    always @(posedge CLK) begin
        if (RST) wptr <= 0;
        else if (wd_pop) wptr <= wptr + 1;
    end
    assign wdata = wq[wptr[3:0]];

    // SRAM model: unwritten words read back as their own index.
    logic [35:0] mem [0:15];
    logic [15:0] wr_seen = '0;
    logic [3:0]  sram_a = '0;
    logic [35:0] sram_q;
    assign dq_in = sram_q;

    always @(posedge CLK) begin : sram_model
        logic [3:0]  a;
        logic [35:0] word;
        a = sram_a;
        if (!CE1_N && !ADSC_N) a = ADDR[3:0];
        else if (!ADV_N) a = {a[3:2], a[1:0] + 2'd1};
        if (!ADSC_N || !ADV_N) begin
            sram_a <= a;
            word = wr_seen[a] ? mem[a] : 36'(a);
            if (!BWE_N) begin
                if (!BWa_N) word[8:0]   = dq_out[8:0];
                if (!BWb_N) word[17:9]  = dq_out[17:9];
                if (!BWc_N) word[26:18] = dq_out[26:18];
                if (!BWd_N) word[35:27] = dq_out[35:27];
                mem[a]     <= word;
                wr_seen[a] <= 1'b1;
            end else begin
                sram_q <= word;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of stimulus, required end before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [18:0] a, input logic b, input logic [3:0] e);
        req    = 1'b1;
        we     = w;
        addr   = a;
        burst4 = b;
        be     = e;
        tick();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".ack"}, 64'(ack), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".wd_pop"}, 64'(wd_pop), 64'd0);
        chk({tag, ".rvalid"}, 64'(rdata_valid), 64'd0);
        chk({tag, ".rdata"}, 64'(rdata), 64'd0);
        chk({tag, ".rbeat"}, 64'(rbeat), 64'd0);
        chk({tag, ".ADDR"}, 64'(ADDR), 64'd0);
        chk({tag, ".ctl_n"}, 64'({ADSC_N, ADV_N, OE_N, BWE_N, CE1_N}), 64'h1F);
        chk({tag, ".bw_n"}, 64'({BWd_N, BWc_N, BWb_N, BWa_N}), 64'hF);
        chk({tag, ".ZZ"}, 64'(ZZ), 64'd0);
        chk({tag, ".dq_oe"}, 64'(dq_oe), 64'd0);
    endtask

    // Four-beat read from a; rdata expected from e0..e3, rbeat from a[1:0].
    task automatic read_burst(input string tag, input logic [18:0] a,
                              input logic [35:0] e0, input logic [35:0] e1,
                              input logic [35:0] e2, input logic [35:0] e3);
        logic [35:0] ex [4];
        logic [1:0]  w;
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        w = a[1:0];
        issue(1'b0, a, 1'b1, 4'h0);
        chk({tag, ".ack"}, 64'(ack), 64'd1);
        chk({tag, ".c1_adsc_oe"}, 64'({ADSC_N, OE_N, dq_oe}), 64'd0);
        chk({tag, ".ADDR"}, 64'(ADDR), 64'(a));
        req = 1'b0;
        tick();
        chk({tag, ".c2_adv_adsc"}, 64'({ADV_N, ADSC_N}), 64'b01);
        chk({tag, ".c2_rvalid"}, 64'(rdata_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk({tag, ".rvalid"}, 64'(rdata_valid), 64'd1);
            chk({tag, ".rbeat"}, 64'(rbeat), 64'(w));
            chk({tag, ".rdata"}, 64'(rdata), 64'(ex[k]));
            w = w + 2'd1;
            if (k == 2) chk({tag, ".tail_oe_adv"}, 64'({OE_N, ADV_N}), 64'b01);
            if (k == 3) chk({tag, ".idle_oe_busy"}, 64'({OE_N, busy}), 64'b10);
        end
        tick();
        chk({tag, ".end_rvalid"}, 64'(rdata_valid), 64'd0);
    endtask

    task automatic write_burst(input string tag, input logic [18:0] a, input int base);
        issue(1'b1, a, 1'b1, 4'hF);
        chk({tag, ".ack"}, 64'(ack), 64'd1);
        chk({tag, ".c1_pins"}, 64'({ADSC_N, BWE_N, wd_pop, dq_oe}), 64'b0011);
        chk({tag, ".dq_out0"}, 64'(dq_out), 64'(wq[base]));
        req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk({tag, ".adv_adsc_pop"}, 64'({ADV_N, ADSC_N, wd_pop}), 64'b011);
            chk({tag, ".dq_out"}, 64'(dq_out), 64'(wq[base + k]));
        end
        tick();
        chk({tag, ".end_pop_oe_busy"}, 64'({wd_pop, dq_oe, busy}), 64'd0);
    endtask

    initial begin
        RST    = 1'b1;
        req    = 1'b0;
        we     = 1'b0;
        addr   = '0;
        burst4 = 1'b0;
        be     = '0;
        wq[0]  = 36'h123456789;
        wq[1]  = 36'hFEDCBA987;
        wq[2]  = 36'h111111111;
        wq[3]  = 36'h222222222;
        wq[4]  = 36'h333333333;
        wq[5]  = 36'h444444444;
        wq[6]  = 36'h555555555;
        wq[7]  = 36'h666666666;
        wq[8]  = 36'h777777777;
        wq[9]  = 36'h888888888;
        for (int i = 10; i < 16; i++) wq[i] = '0;

        tick(); tick(); tick();
        check_reset("rst");
        chk("const_pins", 64'({GW_N, ADSP_N, CE2, CE3_N, MODE}), 64'b11100);
        RST = 1'b0;
        tick();

        // Single write, be=0101 -> lanes a and c only.
        issue(1'b1, 19'h00005, 1'b0, 4'b0101);
        chk("wr1.ack", 64'(ack), 64'd1);
        chk("wr1.adsc_ce", 64'({ADSC_N, CE1_N}), 64'd0);
        chk("wr1.ADDR", 64'(ADDR), 64'h5);
        chk("wr1.bw_n", 64'({BWd_N, BWc_N, BWb_N, BWa_N}), 64'b1010);
        chk("wr1.bwe_oe", 64'({BWE_N, OE_N}), 64'b01);
        chk("wr1.pop_dqoe_busy", 64'({wd_pop, dq_oe, busy}), 64'b111);
        chk("wr1.dq_out", 64'(dq_out), 64'h123456789);
        req = 1'b0;
        tick();
        chk("wr1.end", 64'({ack, ADSC_N, wd_pop, dq_oe, BWE_N, busy}), 64'b010010);

        // Burst from 6 wraps 6,7,4,5; word 5 keeps only lanes a and c of the write.
        read_burst("rd6", 19'h00006, 36'h6, 36'h7, 36'h4, 36'h003440189);

        // Read then a write that is already pending: bus turnaround.
        issue(1'b0, 19'h00008, 1'b1, 4'h0);
        chk("ta.rd_ack", 64'(ack), 64'd1);
        we     = 1'b1;
        addr   = 19'h00009;
        burst4 = 1'b0;
        be     = 4'hF;
        tick(); tick(); tick(); tick();
        chk("ta.tail", 64'({OE_N, dq_oe}), 64'b00);
        tick();
        chk("ta.gap", 64'({OE_N, dq_oe, ack}), 64'b100);
        tick();
        chk("ta.wr_ack", 64'({ack, dq_oe, wd_pop, OE_N}), 64'b1111);
        chk("ta.wr_ADDR", 64'(ADDR), 64'h9);
        chk("ta.wr_dq", 64'(dq_out), 64'hFEDCBA987);
        req = 1'b0;
        tick();
        chk("ta.end", 64'(dq_oe), 64'd0);

        // Back-to-back burst writes then read-back of all 8 words.
        write_burst("wb0", 19'h00000, 2);
        write_burst("wb4", 19'h00004, 6);
        read_burst("rb0", 19'h00000, wq[2], wq[3], wq[4], wq[5]);
        read_burst("rb4", 19'h00004, wq[6], wq[7], wq[8], wq[9]);

        // Reset during the second beat of a burst read.
        issue(1'b0, 19'h00000, 1'b1, 4'h0);
        chk("rstmid.ack", 64'(ack), 64'd1);
        req = 1'b0;
        tick();
        chk("rstmid.beat2", 64'(ADV_N), 64'd0);
        RST = 1'b1;
        tick();
        check_reset("rstmid");
        RST = 1'b0;

        // That cycle is idle cycle 1; ZZ must rise in cycle 65.
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("rstmid.no_rvalid", 64'(rdata_valid), 64'd0);
        end
        for (int i = 5; i <= 64; i++) tick();
        chk("zz.c64", 64'(ZZ), 64'd0);
        tick();
        chk("zz.c65", 64'({ZZ, busy}), 64'b11);

        // Wake: ZZ drops next cycle, ack three cycles after that.
        req    = 1'b1;
        we     = 1'b0;
        addr   = 19'h00009;
        burst4 = 1'b0;
        be     = 4'h0;
        tick();
        chk("wake.w1", 64'({ZZ, ack, busy}), 64'b001);
        tick();
        chk("wake.w2", 64'({ZZ, ack, busy}), 64'b001);
        tick();
        chk("wake.idle", 64'({ZZ, ack, busy}), 64'b000);
        tick();
        chk("wake.ack", 64'({ack, ADSC_N, ZZ}), 64'b100);
        req = 1'b0;
        tick(); tick();
        chk("wake.rvalid", 64'(rdata_valid), 64'd1);
        chk("wake.rdata", 64'(rdata), 64'hFEDCBA987);
        chk("wake.rbeat", 64'(rbeat), 64'd1);
        tick();
        chk("wake.end", 64'({rdata_valid, busy}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
